hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline control unit for the five-stage core. It generates the stall, flush and forwarding controls that drive the fetch, decode, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, resolves taken branches/jumps signalled from EX, and freezes the pipeline while a data-memory access waits for `dmem_ready`, with a timeout. It also keeps saturating stall/flush event counters for debug.

## Interface
- `WIDTH`, 5: register-address width.
- `TIMEOUT`, 15: maximum cycles spent in MEM_WAIT before abort; legal range 1..255.
- `CNT_W`, 16: width of the event counters.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rs1D`, `rs2D` in WIDTH: source registers of the instruction in ID.
- `useRs1D`, `useRs2D` in 1: ID instruction actually reads rs1/rs2.
- `rs1E`, `rs2E`, `rdE` in WIDTH: source and destination registers in EX.
- `memReadE` in 1: the EX instruction is a load.
- `PCSelE` in 1: taken branch/jump resolved in EX.
- `rdM` in WIDTH, `RegWEnM` in 1: MEM-stage destination and write enable.
- `rdW` in WIDTH, `RegWEnW` in 1: WB-stage destination and write enable.
- `memReqM` in 1: MEM-stage instruction accesses data memory this cycle.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `stallF`, `stallD`, `stallE`, `stallM` out 1: hold the corresponding pipeline register.
- `flushD`, `flushE` out 1: load a bubble (all zero) into IF/ID or ID/EX.
- `fwdA`, `fwdB` out 2: ALU operand source. 00 = register file, 10 = MEM result, 01 = WB result.
- `mem_err` out 1: sticky flag, set on a MEM_WAIT timeout.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- **FSM states:** RUN and MEM_WAIT. Reset state is RUN.
- **RUN to MEM_WAIT:** when `memReqM & ~dmem_ready`.
- **MEM_WAIT to RUN:** on `dmem_ready`, or when the timeout counter reaches TIMEOUT.
- **Timeout counter:** 8-bit. Cleared on entry to MEM_WAIT and incremented each cycle spent in MEM_WAIT.
- **Timeout exit:** sets `mem_err`. `mem_err` is cleared only by `rst`.
- **Memory freeze:** asserted combinationally whenever `memReqM & ~dmem_ready`, in RUN or in MEM_WAIT. While frozen, `stallF`, `stallD`, `stallE` and `stallM` are all 1 and `flushD` and `flushE` are 0. Freeze has top priority and masks branch and load-use handling.
- **Timeout cycle:** on the cycle where the timeout expires, the freeze is released even if `dmem_ready` is still 0. The bench treats the access as failed.
- **Branch flush (not frozen):** `PCSelE` gives `flushD=1` and `flushE=1`, with no stalls. Branch flush takes priority over load-use.
- **Load-use (not frozen, no branch):** the hazard is `memReadE & (rdE != 0) & ((useRs1D & rs1D==rdE) | (useRs2D & rs2D==rdE))`. It gives `stallF=1`, `stallD=1` and `flushE=1`, which inserts exactly one bubble.
- **Forwarding, operand A:**
  - `fwdA=10` if `RegWEnM & rdM!=0 & rdM==rs1E`.
  - else `fwdA=01` if `RegWEnW & rdW!=0 & rdW==rs1E`.
  - else `fwdA=00`.
  - `fwdB` uses the same rules with `rs2E`. MEM beats WB. Register x0 is never forwarded. Forwarding is evaluated even when stalled.
- **stall_cnt:** +1 on every cycle where `stallF` is 1.
- **flush_cnt:** +1 on every cycle where `flushD` or `flushE` is 1, counted once per cycle.
- **Counter saturation:** both counters saturate at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the current state, with zero latency. The FSM, timeout counter, `mem_err` and event counters are registered.
- **Reset:** state = RUN, timeout counter = 0, `mem_err` = 0, `stall_cnt` = 0, `flush_cnt` = 0. With all inputs 0, every stall/flush output is 0 and `fwdA`/`fwdB` are 00.
- **Reset asserted mid-MEM_WAIT:** returns to RUN immediately and asynchronously. Counters clear and `mem_err` clears.
- **Load-use cost:** exactly 1 stall cycle. On the next edge the load is in MEM, so the hazard clears without FSM involvement.
- **Freeze length:** with `dmem_ready` arriving N cycles after the request (N ≤ TIMEOUT), stall outputs stay high for exactly N cycles.
- **Timeout:** the freeze lasts TIMEOUT+1 cycles. `mem_err` reads 1 from the following cycle.
- **Simultaneous branch, load-use and memory wait:** only the freeze is visible. After release, the branch and load-use are re-evaluated from the then-current inputs.
- Back-to-back memory waits are legal: MEM_WAIT may be re-entered in the cycle immediately after RUN is reached.

## Test plan
- **Load-use:** rdE=5, memReadE=1, rs1D=5, useRs1D=1 -> for one cycle stallF=stallD=flushE=1, flushD=0; stall_cnt goes 0 to 1.
- **Load-use on x0:** same as above with rdE=0 -> all stall/flush outputs 0.
- **Branch with load-use:** PCSelE=1 together with load-use conditions -> flushD=flushE=1, stallF=0; flush_cnt +1.
- **Forwarding priority:** rs1E=rs2E=7, rdM=rdW=7, RegWEnM=RegWEnW=1 -> fwdA=fwdB=10. With RegWEnM=0 -> 01. With rdM=rdW=0 -> 00.
- **Memory wait:** memReqM=1, dmem_ready rises after 3 cycles -> stallF/D/E/M high for exactly 3 cycles, FSM returns to RUN, mem_err=0.
- **Timeout and reset:** TIMEOUT=4 with dmem_ready held at 0 -> freeze lasts 5 cycles, then mem_err=1 and sticky. Assert rst mid-MEM_WAIT -> mem_err=0, counters=0, state=RUN asynchronously.

Source files
------------

// File: rtl/hazard_if.sv
// hazard_if: bundles the hazard unit's pipeline-side signals.
//   master : pipeline/bench side. Drives register addresses, load/branch/
//            memory status and the write enables; reads the controls back.
//   slave  : hazard_unit side. Returns stall/flush/forward controls,
//            mem_err and the debug event counters.
interface hazard_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] rs1D;
    logic [WIDTH-1:0] rs2D;
    logic             useRs1D;
    logic             useRs2D;
    logic [WIDTH-1:0] rs1E;
    logic [WIDTH-1:0] rs2E;
    logic [WIDTH-1:0] rdE;
    logic             memReadE;
    logic             PCSelE;
    logic [WIDTH-1:0] rdM;
    logic             RegWEnM;
    logic [WIDTH-1:0] rdW;
    logic             RegWEnW;
    logic             memReqM;
    logic             dmem_ready;

    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, memReadE, PCSelE,
               rdM, RegWEnM, rdW, RegWEnW, memReqM, dmem_ready,
        input  stallF, stallD, stallE, stallM, flushD, flushE, fwdA, fwdB,
               mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, memReadE, PCSelE,
               rdM, RegWEnM, rdW, RegWEnW, memReqM, dmem_ready,
        output stallF, stallD, stallE, stallM, flushD, flushE, fwdA, fwdB,
               mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control for the five-stage pipeline.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   hz       : hazard_if slave. Carries the ID/EX/MEM/WB hazard inputs and
//              the memory handshake. Returns the stallF/D/E/M, flushD/E and
//              fwdA/B controls, the sticky mem_err flag and the saturating
//              stall/flush event counters.
//
// state    | meaning
// RUN      | normal flow: branch flush, load-use stall, freeze on memory wait
// MEM_WAIT | waiting on dmem_ready; leaves on ready or after TIMEOUT cycles
module hazard_unit #(
    parameter int WIDTH   = 5,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0]       TMO_MAX = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_pend, tmo_hit, freeze, load_use;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

    // MEM result beats WB result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [WIDTH-1:0] rs,
        input logic [WIDTH-1:0] rd_m, input logic wen_m,
        input logic [WIDTH-1:0] rd_w, input logic wen_w
    );
        if (wen_m && rd_m != '0 && rd_m == rs)
            return 2'b10;
        else if (wen_w && rd_w != '0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        mem_pend = hz.memReqM & ~hz.dmem_ready;
        // On the timeout cycle the freeze drops even though the memory
        // never answered; the access is abandoned and mem_err set.
        tmo_hit  = (state_q == MEM_WAIT) && (tmo_q == TMO_MAX);
        freeze   = mem_pend & ~tmo_hit;
        load_use = hz.memReadE && (hz.rdE != '0) &&
                   ((hz.useRs1D && hz.rs1D == hz.rdE) ||
                    (hz.useRs2D && hz.rs2D == hz.rdE));

        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (hz.PCSelE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            RUN: begin
                if (mem_pend) begin
                    state_d = MEM_WAIT;
                    tmo_d   = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_d = RUN;
                    tmo_d   = 8'd0;
                end else if (tmo_hit) begin
                    state_d   = RUN;
                    tmo_d     = 8'd0;
                    mem_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
                tmo_d   = 8'd0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if ((flush_d || flush_e) && flush_cnt_q != CNT_MAX)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            tmo_q       <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stallF    = stall_f;
    assign hz.stallD    = stall_d;
    assign hz.stallE    = stall_e;
    assign hz.stallM    = stall_m;
    assign hz.flushD    = flush_d;
    assign hz.flushE    = flush_e;
    assign hz.fwdA      = fwd_sel(hz.rs1E, hz.rdM, hz.RegWEnM, hz.rdW, hz.RegWEnW);
    assign hz.fwdB      = fwd_sel(hz.rs2E, hz.rdM, hz.RegWEnM, hz.rdW, hz.RegWEnW);
    assign hz.mem_err   = mem_err_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
    localparam int W   = 5;
    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_if #(.WIDTH(W), .CNT_W(CW)) hz();

    hazard_unit #(.WIDTH(W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    typedef struct {
        logic [W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic useRs1D, useRs2D, memReadE, PCSelE, RegWEnM, RegWEnW, memReqM, dmem_ready;
        logic sF, sD, sE, sM, fD, fE;
        logic [1:0] fwdA, fwdB;
    } vec_t;

    typedef struct {
        logic sF, sD, sE, sM, fD, fE;
        logic [1:0] fwdA, fwdB;
        int sc, fc;
        logic err;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int total = 0;
    int bad = 0;
    int exp_sc = 0;
    int exp_fc = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.rs1D = v.rs1D; hz.rs2D = v.rs2D; hz.useRs1D = v.useRs1D; hz.useRs2D = v.useRs2D;
        hz.rs1E = v.rs1E; hz.rs2E = v.rs2E; hz.rdE = v.rdE; hz.memReadE = v.memReadE;
        hz.PCSelE = v.PCSelE; hz.rdM = v.rdM; hz.RegWEnM = v.RegWEnM;
        hz.rdW = v.rdW; hz.RegWEnW = v.RegWEnW; hz.memReqM = v.memReqM;
        hz.dmem_ready = v.dmem_ready;
    endtask

    // Drive one cycle of stimulus, queue its expectation, check, then
    // advance the counter model for the coming clock edge.
    task automatic step(input string nm, input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v);
        sb_q.push_back('{v.sF, v.sD, v.sE, v.sM, v.fD, v.fE, v.fwdA, v.fwdB,
                         exp_sc, exp_fc, exp_err});
        #1;
        e = sb_q.pop_front();
        chk({nm, ".stallF"}, int'(hz.stallF), int'(e.sF));
        chk({nm, ".stallD"}, int'(hz.stallD), int'(e.sD));
        chk({nm, ".stallE"}, int'(hz.stallE), int'(e.sE));
        chk({nm, ".stallM"}, int'(hz.stallM), int'(e.sM));
        chk({nm, ".flushD"}, int'(hz.flushD), int'(e.fD));
        chk({nm, ".flushE"}, int'(hz.flushE), int'(e.fE));
        chk({nm, ".fwdA"}, int'(hz.fwdA), int'(e.fwdA));
        chk({nm, ".fwdB"}, int'(hz.fwdB), int'(e.fwdB));
        chk({nm, ".stall_cnt"}, int'(hz.stall_cnt), e.sc);
        chk({nm, ".flush_cnt"}, int'(hz.flush_cnt), e.fc);
        chk({nm, ".mem_err"}, int'(hz.mem_err), int'(e.err));
        if (v.sF && exp_sc < CMAX) exp_sc++;
        if ((v.fD || v.fE) && exp_fc < CMAX) exp_fc++;
    endtask

    function automatic vec_t zv();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t lu(input vec_t b);
        vec_t v;
        v = b;
        v.rdE = 5; v.memReadE = 1; v.rs1D = 5; v.useRs1D = 1;
        return v;
    endfunction

    function automatic vec_t frz(input vec_t b);
        vec_t v;
        v = b;
        v.sF = 1; v.sD = 1; v.sE = 1; v.sM = 1; v.fD = 0; v.fE = 0;
        return v;
    endfunction

    initial begin
        vec_t v;
        vec_t b;

        drive(zv());
        #12;
        chk("rst.stallF", int'(hz.stallF), 0);
        chk("rst.flushE", int'(hz.flushE), 0);
        chk("rst.fwdA", int'(hz.fwdA), 0);
        chk("rst.stall_cnt", int'(hz.stall_cnt), 0);
        chk("rst.flush_cnt", int'(hz.flush_cnt), 0);
        chk("rst.mem_err", int'(hz.mem_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- table-driven combinational vectors ----
        v = zv(); tbl.push_back(v);
        v = lu(zv()); v.sF = 1; v.sD = 1; v.fE = 1; tbl.push_back(v);
        v = lu(zv()); v.rdE = 0; v.rs1D = 0; tbl.push_back(v);
        v = lu(zv()); v.PCSelE = 1; v.fD = 1; v.fE = 1; tbl.push_back(v);
        v = zv(); v.rdE = 9; v.memReadE = 1; v.rs2D = 9; v.useRs2D = 1;
        v.sF = 1; v.sD = 1; v.fE = 1; tbl.push_back(v);
        v = lu(zv()); v.useRs1D = 0; tbl.push_back(v);
        v = lu(zv()); v.memReadE = 0; tbl.push_back(v);
        v = zv(); v.rs1E = 7; v.rs2E = 7; v.rdM = 7; v.rdW = 7; v.RegWEnM = 1; v.RegWEnW = 1;
        v.fwdA = 2'b10; v.fwdB = 2'b10; tbl.push_back(v);
        v.RegWEnM = 0; v.fwdA = 2'b01; v.fwdB = 2'b01; tbl.push_back(v);
        v.RegWEnM = 1; v.rdM = 0; v.rdW = 0; v.fwdA = 2'b00; v.fwdB = 2'b00; tbl.push_back(v);
        v = zv(); v.rs1E = 3; v.rdM = 3; v.RegWEnM = 1; v.rs2E = 4; v.rdW = 4; v.RegWEnW = 1;
        v.fwdA = 2'b10; v.fwdB = 2'b01; tbl.push_back(v);
        v = lu(zv()); v.memReqM = 1; v.dmem_ready = 1; v.sF = 1; v.sD = 1; v.fE = 1; tbl.push_back(v);
        v = zv(); v.PCSelE = 1; v.rs1E = 2; v.rdW = 2; v.RegWEnW = 1;
        v.fD = 1; v.fE = 1; v.fwdA = 2'b01; tbl.push_back(v);

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // ---- memory wait of 3 cycles with branch + load-use pending ----
        b = lu(zv()); b.PCSelE = 1; b.memReqM = 1;
        b.rs1E = 6; b.rdM = 6; b.RegWEnM = 1; b.fwdA = 2'b10;
        for (int i = 0; i < 3; i++) step($sformatf("wait%0d", i), frz(b));
        v = b; v.dmem_ready = 1; v.fD = 1; v.fE = 1;
        step("wait_rel", v);

        // ---- back-to-back wait that times out: TIMEOUT+1 frozen cycles ----
        b = zv(); b.memReqM = 1;
        for (int i = 0; i < TMO + 1; i++) step($sformatf("tmo%0d", i), frz(b));
        step("tmo_rel", b);
        exp_err = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("sticky%0d", i), zv());

        // ---- drive both counters into saturation ----
        v = lu(zv()); v.sF = 1; v.sD = 1; v.fE = 1;
        for (int i = 0; i < 6; i++) step($sformatf("sat_lu%0d", i), v);
        v = zv(); v.PCSelE = 1; v.fD = 1; v.fE = 1;
        for (int i = 0; i < 5; i++) step($sformatf("sat_br%0d", i), v);
        step("sat_chk", zv());

        // ---- asynchronous reset in the middle of MEM_WAIT ----
        b = zv(); b.memReqM = 1;
        step("mw_a", frz(b));
        step("mw_b", frz(b));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.stall_cnt", int'(hz.stall_cnt), 0);
        chk("arst.flush_cnt", int'(hz.flush_cnt), 0);
        chk("arst.mem_err", int'(hz.mem_err), 0);
        exp_sc = 0;
        exp_fc = 0;
        exp_err = 1'b0;
        drive(zv());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // A fresh wait after reset must again last exactly TIMEOUT+1 cycles.
        for (int i = 0; i < TMO + 1; i++) step($sformatf("post%0d", i), frz(b));
        step("post_rel", b);
        exp_err = 1'b1;
        step("post_err", zv());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
